// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the bus hub and its helpers.
//   hub_state_t  : hub FSM state encoding (IDLE, DECODE, BUSY, RESP)
//   HUB_ERR_DATA : read data returned on an error completion
//   idx_width()  : index width for an N-entry select, never below 1 bit
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } hub_state_t;

    localparam int HUB_ERR_DATA = 0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_hub_n_if.sv
// -----------------------------------------------------------------------------
// bus_hub_n_if
// Host request/completion signals plus the broadcast device bus.
// Handshake: the host raises host_ren/host_wen with address/data/mask and holds
// them until a single-cycle host_ready; host_error and host_data_read are only
// meaningful in that cycle. Devices decode device_address themselves, report
// device_active combinationally, and finish a strobed access with device_ready.
//   slave  : the hub's view (takes host requests, drives the device bus)
//   master : the environment's view (host plus devices)
// -----------------------------------------------------------------------------
interface bus_hub_n_if #(
    parameter int N_DEVICES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [ADDR_W-1:0]             host_address;
    logic [DATA_W-1:0]             host_data_write;
    logic [DATA_W/8-1:0]           host_write_mask;
    logic                          host_ren;
    logic                          host_wen;
    logic [DATA_W-1:0]             host_data_read;
    logic                          host_ready;
    logic                          host_error;

    logic [N_DEVICES*ADDR_W-1:0]   device_address;
    logic [N_DEVICES*DATA_W-1:0]   device_data_write;
    logic [N_DEVICES*DATA_W/8-1:0] device_write_mask;
    logic [N_DEVICES-1:0]          device_ren;
    logic [N_DEVICES-1:0]          device_wen;
    logic [N_DEVICES-1:0]          device_ready;
    logic [N_DEVICES*DATA_W-1:0]   device_data_read;
    logic [N_DEVICES-1:0]          device_active;

    modport slave (
        input  host_address, host_data_write, host_write_mask, host_ren, host_wen,
        output host_data_read, host_ready, host_error,
        output device_address, device_data_write, device_write_mask,
        output device_ren, device_wen,
        input  device_ready, device_data_read, device_active
    );

    modport master (
        output host_address, host_data_write, host_write_mask, host_ren, host_wen,
        input  host_data_read, host_ready, host_error,
        input  device_address, device_data_write, device_write_mask,
        input  device_ren, device_wen,
        output device_ready, device_data_read, device_active
    );
endinterface

// File: rtl/bus_prio_enc.sv
// -----------------------------------------------------------------------------
// bus_prio_enc
// Priority encoder: returns the highest set index of req and whether any bit
// is set. When nothing is set idx is 0.
//   req : request vector (N bits)
//   idx : index of the highest set bit (IDX_W bits)
//   any : at least one bit of req is set
// -----------------------------------------------------------------------------
module bus_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last hit, i.e. the highest index, wins.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_hub_n.sv
// -----------------------------------------------------------------------------
// bus_hub_n
// Hub between one host and N self-decoding devices. A request is registered,
// broadcast to every device, and only the device claiming the address (highest
// index if several claim it) is strobed until it answers or the access times
// out. Unmapped and timed-out accesses complete with host_error and zero data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : host request/completion and device bus (slave modport)
//   dbg_state  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module bus_hub_n
    import bus_pkg::*;
#(
    parameter int N_DEVICES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    bus_hub_n_if.slave bus,
    output hub_state_t dbg_state
);
    localparam int MASK_W = DATA_W / 8;
    localparam int SEL_W  = idx_width(N_DEVICES);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    hub_state_t        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [MASK_W-1:0] mask_q,    mask_d;
    logic              ren_q,     ren_d;
    logic              wen_q,     wen_d;
    logic [SEL_W-1:0]  sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              err_q,     err_d;

    logic [SEL_W-1:0]     enc_idx;
    logic                 enc_any;
    logic                 sel_ready;
    logic [DATA_W-1:0]    sel_rdata;
    logic [N_DEVICES-1:0] dev_ren;
    logic [N_DEVICES-1:0] dev_wen;

    bus_prio_enc #(.N(N_DEVICES), .IDX_W(SEL_W)) u_prio_enc (
        .req (bus.device_active),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Only the selected device's answer is ever looked at.
    assign sel_ready = bus.device_ready[sel_idx_q];
    assign sel_rdata = bus.device_data_read[int'(sel_idx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        sel_idx_d = sel_idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.host_ren || bus.host_wen) begin
                    addr_d  = bus.host_address;
                    wdata_d = bus.host_data_write;
                    mask_d  = bus.host_write_mask;
                    ren_d   = bus.host_ren;
                    wen_d   = bus.host_wen;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // device_active now reflects the registered address.
                sel_idx_d = enc_idx;
                if (enc_any) begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(HUB_ERR_DATA);
                    state_d = RESP;
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    err_d   = 1'b0;
                    rdata_d = sel_rdata;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(HUB_ERR_DATA);
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturates rather than wraps when the timeout is disabled.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            sel_idx_q <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            sel_idx_q <= sel_idx_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Strobes are a pure decode of registered state, so reset drops them at once.
    always_comb begin
        dev_ren = '0;
        dev_wen = '0;
        if (state_q == BUSY) begin
            dev_ren[sel_idx_q] = ren_q;
            dev_wen[sel_idx_q] = wen_q;
        end
    end

    assign bus.device_address    = {N_DEVICES{addr_q}};
    assign bus.device_data_write = {N_DEVICES{wdata_q}};
    assign bus.device_write_mask = {N_DEVICES{mask_q}};
    assign bus.device_ren        = dev_ren;
    assign bus.device_wen        = dev_wen;
    assign bus.host_ready        = (state_q == RESP);
    assign bus.host_error        = err_q;
    assign bus.host_data_read    = rdata_q;
    assign dbg_state             = state_q;
endmodule

// File: tb/tb_bus_hub_n.sv
// -----------------------------------------------------------------------------
// tb_bus_hub_n
// Bench for bus_hub_n with four modelled devices. Each device decodes address
// bits [15:12] from a fixed map, answers a configurable number of cycles after
// it is first strobed (or never), and returns a configurable read word.
// -----------------------------------------------------------------------------
module tb_bus_hub_n;
    import bus_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int TO    = 8;
    localparam int NEVER = 1000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_hub_n_if #(.N_DEVICES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    hub_state_t dbg_state;

    bus_hub_n #(.N_DEVICES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- device models ----------------
    int          dly [N];
    logic [DW-1:0] rdv [N];
    int          busy_cnt [N];
    logic        ready_noise = 1'b0;
    logic [DW:0] exp_q [$];

    function automatic logic [N-1:0] decode_map(input logic [AW-1:0] a);
        case (a[15:12])
            4'h1:    return 4'b0010;
            4'h2:    return 4'b0100;
            4'h3:    return 4'b1001;
            4'h4:    return 4'b1000;
            4'h5:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        logic [N-1:0] hit;
        logic         stb;
        hit = '0;
        stb = 1'b0;
        bus.device_active    = '0;
        bus.device_ready     = '0;
        bus.device_data_read = '0;
        for (int i = 0; i < N; i++) begin
            hit = decode_map(bus.device_address[i*AW +: AW]);
            stb = bus.device_ren[i] | bus.device_wen[i];
            bus.device_active[i] = hit[i];
            // Unstrobed devices may chatter on ready when noise is on.
            bus.device_ready[i] = stb ? (dly[i] != NEVER && busy_cnt[i] >= dly[i]) : ready_noise;
            bus.device_data_read[i*DW +: DW] = rdv[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            busy_cnt[i] <= (bus.device_ren[i] | bus.device_wen[i]) ? busy_cnt[i] + 1 : 0;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: which device answers, after how long, and with what.
    task automatic model(input logic [AW-1:0] addr, output int tgt, output int lat,
                         output int nstb, output logic err, output logic [DW-1:0] data);
        logic [N-1:0] hits;
        hits = decode_map(addr);
        tgt  = -1;
        for (int i = N - 1; i >= 0; i--)
            if (hits[i] && tgt < 0) tgt = i;
        if (tgt < 0) begin
            lat = 2; nstb = 0; err = 1'b1; data = '0;
        end else if (dly[tgt] < TO) begin
            lat = 3 + dly[tgt]; nstb = dly[tgt] + 1; err = 1'b0; data = rdv[tgt];
        end else begin
            lat = 2 + TO; nstb = TO; err = 1'b1; data = '0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic r,
                           input logic w, input logic [DW-1:0] wd, input logic [MW-1:0] m);
        int tgt, lat, nstb, cyc, seen, ti;
        logic e, done, stray, obs_err;
        logic [DW-1:0] d, obs_data;
        logic [N-1:0] allowed;
        logic [DW:0] exp;
        model(addr, tgt, lat, nstb, e, d);
        exp_q.push_back({e, d});
        ti      = (tgt < 0) ? 0 : tgt;
        allowed = (tgt < 0) ? '0 : (N'(1) << tgt);
        @(negedge clk);
        bus.host_address    = addr;
        bus.host_ren        = r;
        bus.host_wen        = w;
        bus.host_data_write = wd;
        bus.host_write_mask = m;
        cyc = 0; seen = 0; done = 1'b0; stray = 1'b0;
        obs_err = 1'b0; obs_data = '0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if ((bus.device_ren | bus.device_wen) != '0) begin
                seen++;
                if ((bus.device_ren & ~(r ? allowed : '0)) != '0) stray = 1'b1;
                if ((bus.device_wen & ~(w ? allowed : '0)) != '0) stray = 1'b1;
                if (tgt >= 0 && (bus.device_ren[ti] !== r || bus.device_wen[ti] !== w)) stray = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (bus.device_address[i*AW +: AW] !== addr) stray = 1'b1;
                    if (bus.device_data_write[i*DW +: DW] !== wd) stray = 1'b1;
                    if (bus.device_write_mask[i*MW +: MW] !== m) stray = 1'b1;
                end
            end
            if (bus.host_ready === 1'b1) begin
                done     = 1'b1;
                obs_err  = bus.host_error;
                obs_data = bus.host_data_read;
                bus.host_ren = 1'b0;
                bus.host_wen = 1'b0;
            end
        end
        bus.host_ren = 1'b0;
        bus.host_wen = 1'b0;
        exp = exp_q.pop_front();
        check({tag, " latency"}, done ? 64'(cyc) : 64'hDEAD, 64'(lat));
        check({tag, " error"}, 64'(obs_err), 64'(exp[DW]));
        if (r) check({tag, " rdata"}, 64'(obs_data), 64'(exp[DW-1:0]));
        check({tag, " strobe_cycles"}, 64'(seen), 64'(nstb));
        check({tag, " strobe_target"}, 64'(stray), 64'(0));
        @(posedge clk); #1;
        check({tag, " ready_pulse"}, 64'(bus.host_ready), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [1:0]    k;
        logic [3:0]    reg_sel;
        bus.host_address = '0; bus.host_data_write = '0; bus.host_write_mask = '0;
        bus.host_ren = 1'b0;   bus.host_wen = 1'b0;
        for (int i = 0; i < N; i++) begin dly[i] = 0; rdv[i] = 32'h1000_0000 * (i + 1); end

        // Reset state
        #12;
        check("rst host_ready", 64'(bus.host_ready), 64'(0));
        check("rst host_error", 64'(bus.host_error), 64'(0));
        check("rst host_data_read", 64'(bus.host_data_read), 64'(0));
        check("rst device_strobes", 64'({bus.device_ren, bus.device_wen}), 64'(0));
        check("rst device_address", 64'(bus.device_address[63:0]), 64'(0));
        check("rst device_wdata_mask", 64'({bus.device_write_mask, bus.device_data_write[31:0]}), 64'(0));
        check("rst state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk); rst_n = 1'b1;

        // Zero-wait read from device 2
        rdv[2] = 32'hCAFE_F00D; dly[2] = 0;
        run_txn("rd_dev2", 32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'h0);
        // Write to a device that waits five cycles
        dly[1] = 5;
        run_txn("wr_dev1", 32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 4'b0011);
        // Unmapped
        run_txn("unmapped", 32'h0000_F000, 1'b1, 1'b0, 32'h0, 4'h0);
        // Two claimants, the higher index wins; unselected device chatters on ready
        dly[0] = 0; dly[3] = 1; rdv[0] = 32'h0BAD_0000; rdv[3] = 32'h3333_ABCD;
        ready_noise = 1'b1;
        run_txn("dev0_dev3", 32'h0000_3010, 1'b1, 1'b0, 32'h0, 4'h0);
        ready_noise = 1'b0;
        // Timeout, then a good access
        dly[2] = NEVER;
        run_txn("timeout", 32'h0000_2004, 1'b1, 1'b0, 32'h0, 4'h0);
        dly[2] = 0; rdv[2] = 32'h5A5A_1234;
        run_txn("after_timeout", 32'h0000_2008, 1'b1, 1'b1, 32'hFFFF_0000, 4'b1111);

        // Reset while BUSY
        dly[2] = NEVER;
        @(negedge clk);
        bus.host_address = 32'h0000_2000; bus.host_ren = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst busy_strobe", 64'(bus.device_ren), 64'(4'b0100));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst strobes", 64'({bus.device_ren, bus.device_wen}), 64'(0));
        check("mid_rst host_ready", 64'(bus.host_ready), 64'(0));
        check("mid_rst state", 64'(dbg_state), 64'(IDLE));
        bus.host_ren = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dly[2] = 2; rdv[2] = 32'hFEED_BEEF;
        run_txn("post_rst", 32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'h0);

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                dly[i] = $urandom_range(0, 9);
                rdv[i] = $urandom;
            end
            ready_noise = 1'($urandom_range(0, 1));
            reg_sel = 4'($urandom_range(1, 6));
            a = {16'($urandom), reg_sel, 12'($urandom)};
            k = 2'($urandom_range(1, 3));
            run_txn("random", a, k[0], k[1], 32'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog");
    end
endmodule
